// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared types, DR6/DR7 field positions and byte-mask helper for the breakpoint unit
package debug_pkg;

    typedef enum logic [1:0] {
        RW_EXEC  = 2'b00,
        RW_WRITE = 2'b01,
        RW_IO    = 2'b10,
        RW_RDWR  = 2'b11
    } rw_e;

    typedef enum logic [1:0] {
        LEN_1     = 2'b00,
        LEN_2     = 2'b01,
        LEN_UNDEF = 2'b10,
        LEN_4     = 2'b11
    } len_e;

    localparam int DR7_L         = 0;
    localparam int DR7_G         = 1;
    localparam int DR7_GD        = 13;
    localparam int DR7_RW        = 16;
    localparam int DR7_LEN       = 18;
    localparam int DR7_BP_STRIDE = 4;

    localparam int DR6_B0 = 0;
    localparam int DR6_B1 = 1;
    localparam int DR6_B2 = 2;
    localparam int DR6_B3 = 3;
    localparam int DR6_BD = 13;
    localparam int DR6_BS = 14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACCUM = 2'b01,
        ST_REQ   = 2'b10
    } state_e;

    // Bytes of the dword covered by a breakpoint; the undefined length behaves as one byte.
    function automatic logic [3:0] len_mask(input len_e len, input logic [1:0] low);
        case (len)
            LEN_2:   return 4'b0011 << {low[1], 1'b0};
            LEN_4:   return 4'hF;
            default: return 4'b0001 << low;
        endcase
    endfunction

endpackage

// File: rtl/debug_bp_compare.sv
// rtl/debug_bp_compare.sv - combinational match of one breakpoint against instruction and data traffic
module debug_bp_compare
    import debug_pkg::*;
(
    input  logic        enable,
    input  logic [1:0]  rw,
    input  logic [1:0]  len,
    input  logic [31:0] bp_addr,
    input  logic        insn_start_valid,
    input  logic [31:0] insn_start_addr,
    input  logic        eflags_rf,
    input  logic        access_valid,
    input  logic [29:0] access_addr,
    input  logic [3:0]  access_be,
    input  logic        access_write,
    output logic        data_hit,
    output logic        insn_hit
);

    logic [3:0] byte_mask;
    logic       rw_ok;

    assign byte_mask = len_mask(len_e'(len), bp_addr[1:0]);
    assign rw_ok     = (rw == RW_RDWR) || ((rw == RW_WRITE) && access_write);

    assign data_hit = enable && access_valid && rw_ok
                   && (access_addr == bp_addr[31:2])
                   && ((byte_mask & access_be) != 4'h0);

    assign insn_hit = enable && insn_start_valid && !eflags_rf
                   && (rw == RW_EXEC) && (len == LEN_1)
                   && (insn_start_addr == bp_addr);

endmodule

// File: rtl/debug_breakpoint_unit.sv
// rtl/debug_breakpoint_unit.sv - #DB request generation from DR0-DR3/DR7; DEBUG_BREAKPOINT_SINGLE_STEP_EN adds single-step (BS)
module debug_breakpoint_unit
    import debug_pkg::*;
#(
    parameter int NUM_BP = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NUM_BP-1:0][31:0] dr_addr,
    input  logic [31:0]            dr7,
    input  logic                   insn_start_valid,
    input  logic [31:0]            insn_start_addr,
    input  logic                   eflags_rf,
`ifdef DEBUG_BREAKPOINT_SINGLE_STEP_EN
    input  logic                   eflags_tf,
`endif
    input  logic                   access_valid,
    input  logic [29:0]            access_addr,
    input  logic [3:0]             access_be,
    input  logic                   access_write,
    input  logic                   insn_retire,
    input  logic                   insn_flush,
    input  logic                   dr_access_valid,
    output logic                   debug_req,
    output logic                   debug_fault,
    output logic [15:0]            dr6_status,
    input  logic                   debug_ack,
    output logic                   gd_clear
);

    logic [NUM_BP-1:0] data_hits;
    logic [NUM_BP-1:0] insn_hits;
    logic              gd_hit;
    logic              step_trap;
    logic [15:0]       bs_bit;

    state_e            state_q, state_d;
    logic [NUM_BP-1:0] pending_q, pending_d;
    logic [15:0]       status_q, status_d;
    logic              fault_q, fault_d;
    logic              gd_clear_q, gd_clear_d;

    logic              unused_dr7;
    assign unused_dr7 = ^{dr7[15:14], dr7[12:2*NUM_BP]};

    for (genvar i = 0; i < NUM_BP; i++) begin : g_bp
        debug_bp_compare u_cmp (
            .enable           (dr7[DR7_L + 2*i] | dr7[DR7_G + 2*i]),
            .rw               (dr7[DR7_RW  + DR7_BP_STRIDE*i +: 2]),
            .len              (dr7[DR7_LEN + DR7_BP_STRIDE*i +: 2]),
            .bp_addr          (dr_addr[i]),
            .insn_start_valid (insn_start_valid),
            .insn_start_addr  (insn_start_addr),
            .eflags_rf        (eflags_rf),
            .access_valid     (access_valid),
            .access_addr      (access_addr),
            .access_be        (access_be),
            .access_write     (access_write),
            .data_hit         (data_hits[i]),
            .insn_hit         (insn_hits[i])
        );
    end

    assign gd_hit = dr7[DR7_GD] & dr_access_valid;

`ifdef DEBUG_BREAKPOINT_SINGLE_STEP_EN
    assign step_trap = insn_retire & eflags_tf;
`else
    assign step_trap = 1'b0;
`endif
    assign bs_bit = step_trap ? (16'h1 << DR6_BS) : 16'h0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            status_q   <= '0;
            fault_q    <= 1'b0;
            gd_clear_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            status_q   <= status_d;
            fault_q    <= fault_d;
            gd_clear_q <= gd_clear_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        status_d   = status_q;
        fault_d    = fault_q;
        gd_clear_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Faults pre-empt trap accumulation; GD reports any instruction hits alongside BD.
                if (gd_hit) begin
                    state_d    = ST_REQ;
                    fault_d    = 1'b1;
                    status_d   = (16'h1 << DR6_BD) | 16'(insn_hits);
                    gd_clear_d = 1'b1;
                end else if (|insn_hits) begin
                    state_d  = ST_REQ;
                    fault_d  = 1'b1;
                    status_d = 16'(insn_hits);
                end else if (!insn_flush) begin
                    if (insn_retire && ((|data_hits) || step_trap)) begin
                        state_d  = ST_REQ;
                        fault_d  = 1'b0;
                        status_d = 16'(data_hits) | bs_bit;
                    end else if (|data_hits) begin
                        state_d   = ST_ACCUM;
                        pending_d = data_hits;
                    end
                end
            end
            ST_ACCUM: begin
                if (insn_flush) begin
                    state_d   = ST_IDLE;
                    pending_d = '0;
                end else if (insn_retire) begin
                    state_d   = ST_REQ;
                    fault_d   = 1'b0;
                    status_d  = 16'(pending_q | data_hits) | bs_bit;
                    pending_d = '0;
                end else begin
                    pending_d = pending_q | data_hits;
                end
            end
            ST_REQ: begin
                if (debug_ack) begin
                    state_d   = ST_IDLE;
                    pending_d = '0;
                    status_d  = '0;
                    fault_d   = 1'b0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                pending_d = '0;
                status_d  = '0;
                fault_d   = 1'b0;
            end
        endcase
    end

    assign debug_req   = (state_q == ST_REQ);
    assign debug_fault = fault_q;
    assign dr6_status  = status_q;
    assign gd_clear    = gd_clear_q;

endmodule

// File: tb/tb_debug_breakpoint_unit.sv
// tb/tb_debug_breakpoint_unit.sv - vector table, reset corner case and randomized model check for debug_breakpoint_unit
module tb_debug_breakpoint_unit;

    logic             clock = 1'b0;
    logic             reset_n;
    logic [3:0][31:0] dr_addr;
    logic [31:0]      dr7;
    logic             insn_start_valid;
    logic [31:0]      insn_start_addr;
    logic             eflags_rf;
    logic             eflags_tf;
    logic             access_valid;
    logic [29:0]      access_addr;
    logic [3:0]       access_be;
    logic             access_write;
    logic             insn_retire;
    logic             insn_flush;
    logic             dr_access_valid;
    logic             debug_req;
    logic             debug_fault;
    logic [15:0]      dr6_status;
    logic             debug_ack;
    logic             gd_clear;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    debug_breakpoint_unit #(.NUM_BP(4)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .dr_addr          (dr_addr),
        .dr7              (dr7),
        .insn_start_valid (insn_start_valid),
        .insn_start_addr  (insn_start_addr),
        .eflags_rf        (eflags_rf),
`ifdef DEBUG_BREAKPOINT_SINGLE_STEP_EN
        .eflags_tf        (eflags_tf),
`endif
        .access_valid     (access_valid),
        .access_addr      (access_addr),
        .access_be        (access_be),
        .access_write     (access_write),
        .insn_retire      (insn_retire),
        .insn_flush       (insn_flush),
        .dr_access_valid  (dr_access_valid),
        .debug_req        (debug_req),
        .debug_fault      (debug_fault),
        .dr6_status       (dr6_status),
        .debug_ack        (debug_ack),
        .gd_clear         (gd_clear)
    );

    typedef struct {
        logic [31:0] dr0, dr1, dr2, dr7v;
        logic        isv;
        logic [31:0] isa;
        logic        rf, av;
        logic [29:0] aa;
        logic [3:0]  be;
        logic        wr, ret, fl, dav, ack;
        logic        ereq, efault;
        logic [15:0] est;
        logic        egd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [31:0] d0, d1, d2, d7, input logic isv, input logic [31:0] isa,
                       input logic rf, av, input logic [29:0] aa, input logic [3:0] be,
                       input logic wr, ret, fl, dav, ack, ereq, efault, input logic [15:0] est, input logic egd);
        vec_t v;
        v.dr0 = d0; v.dr1 = d1; v.dr2 = d2; v.dr7v = d7;
        v.isv = isv; v.isa = isa; v.rf = rf; v.av = av; v.aa = aa; v.be = be; v.wr = wr;
        v.ret = ret; v.fl = fl; v.dav = dav; v.ack = ack;
        v.ereq = ereq; v.efault = efault; v.est = est; v.egd = egd;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, got, exp);
        end
    endtask

    task automatic check_outs(input string nm, input int idx, input logic req, fault,
                              input logic [15:0] st, input logic gd);
        chk({nm, ".req"},    idx, 32'(debug_req),   32'(req));
        chk({nm, ".fault"},  idx, 32'(debug_fault), 32'(fault));
        chk({nm, ".status"}, idx, 32'(dr6_status),  32'(st));
        chk({nm, ".gd"},     idx, 32'(gd_clear),    32'(gd));
    endtask

    task automatic idle_inputs();
        dr_addr = '0; dr7 = '0; insn_start_valid = 0; insn_start_addr = '0; eflags_rf = 0; eflags_tf = 0;
        access_valid = 0; access_addr = '0; access_be = '0; access_write = 0;
        insn_retire = 0; insn_flush = 0; dr_access_valid = 0; debug_ack = 0;
    endtask

    // Reference model state: a pending trap exists exactly when m_pend is nonzero.
    logic        m_req, m_fault, m_gd;
    logic [15:0] m_st;
    logic [3:0]  m_pend;

    task automatic calc_hits(output logic [3:0] dh, output logic [3:0] ih);
        for (int i = 0; i < 4; i++) begin
            int unsigned a, rw, ln, mask;
            bit en;
            a    = dr_addr[i];
            en   = dr7[2*i] || dr7[2*i+1];
            rw   = (dr7 >> (16 + 4*i)) & 3;
            ln   = (dr7 >> (18 + 4*i)) & 3;
            if (ln == 1)      mask = 3 << (a & 2);
            else if (ln == 3) mask = 15;
            else              mask = 1 << (a & 3);
            dh[i] = en && access_valid && ((a >> 2) == 32'(access_addr)) && ((mask & access_be) != 0)
                    && (rw == 3 || (rw == 1 && access_write));
            ih[i] = en && insn_start_valid && rw == 0 && ln == 0 && insn_start_addr == a && !eflags_rf;
        end
    endtask

    task automatic model_step();
        logic [3:0] dh, ih, p;
        calc_hits(dh, ih);
        m_gd = 0;
        if (m_req) begin
            if (debug_ack) begin m_req = 0; m_st = 0; m_fault = 0; end
        end else if (m_pend == 0 && dr7[13] && dr_access_valid) begin
            m_req = 1; m_fault = 1; m_st = 16'h2000 | {12'h0, ih}; m_gd = 1;
        end else if (m_pend == 0 && ih != 0) begin
            m_req = 1; m_fault = 1; m_st = {12'h0, ih};
        end else if (insn_flush) begin
            m_pend = 0;
        end else begin
            p = m_pend | dh;
            if (insn_retire && p != 0) begin
                m_req = 1; m_fault = 0; m_st = {12'h0, p}; m_pend = 0;
            end else begin
                m_pend = p;
            end
        end
    endtask

    initial begin
        idle_inputs();
        reset_n = 0;
        repeat (2) @(posedge clock);
        #1;
        check_outs("reset", 0, 0, 0, 16'h0, 0);
        reset_n = 1;

        //   dr0          dr1          dr2          dr7          isv isa          rf av aa       be    wr re fl dv ak  req flt status   gd
        add(32'h1000,    32'h0,       32'h0,       32'h000D0001, 0, 32'h0,       0, 1, 30'h400, 4'h4, 1, 0, 0, 0, 0,  0, 0, 16'h0000, 0);
        add(32'h1000,    32'h0,       32'h0,       32'h000D0001, 0, 32'h0,       0, 0, 30'h0,   4'h0, 0, 1, 0, 0, 0,  1, 0, 16'h0001, 0);
        add(32'h1000,    32'h0,       32'h0,       32'h000D0001, 0, 32'h0,       0, 1, 30'h400, 4'hF, 1, 1, 0, 0, 0,  1, 0, 16'h0001, 0);
        add(32'h1000,    32'h0,       32'h0,       32'h000D0001, 0, 32'h0,       0, 0, 30'h0,   4'h0, 0, 0, 0, 0, 1,  0, 0, 16'h0000, 0);
        add(32'h1000,    32'h0,       32'h0,       32'h000D0001, 0, 32'h0,       0, 1, 30'h400, 4'h4, 0, 0, 0, 0, 0,  0, 0, 16'h0000, 0);
        add(32'h1000,    32'h0,       32'h0,       32'h000D0001, 0, 32'h0,       0, 0, 30'h0,   4'h0, 0, 1, 0, 0, 0,  0, 0, 16'h0000, 0);
        add(32'h1001,    32'h0,       32'h0,       32'h00010001, 0, 32'h0,       0, 1, 30'h400, 4'h1, 1, 1, 0, 0, 0,  0, 0, 16'h0000, 0);
        add(32'h1001,    32'h0,       32'h0,       32'h00010001, 0, 32'h0,       0, 1, 30'h400, 4'h2, 1, 1, 0, 0, 0,  1, 0, 16'h0001, 0);
        add(32'h1001,    32'h0,       32'h0,       32'h00010001, 0, 32'h0,       0, 0, 30'h0,   4'h0, 0, 0, 0, 0, 1,  0, 0, 16'h0000, 0);
        add(32'h0,       32'h2000,    32'h0,       32'h00000008, 1, 32'h2000,    1, 0, 30'h0,   4'h0, 0, 0, 0, 0, 0,  0, 0, 16'h0000, 0);
        add(32'h0,       32'h2000,    32'h0,       32'h00000008, 1, 32'h2000,    0, 0, 30'h0,   4'h0, 0, 0, 0, 0, 0,  1, 1, 16'h0002, 0);
        add(32'h0,       32'h2000,    32'h0,       32'h00000008, 0, 32'h0,       0, 0, 30'h0,   4'h0, 0, 0, 0, 0, 1,  0, 0, 16'h0000, 0);
        add(32'h0,       32'h0,       32'h0,       32'h00002000, 0, 32'h0,       0, 0, 30'h0,   4'h0, 0, 0, 0, 1, 0,  1, 1, 16'h2000, 1);
        add(32'h0,       32'h0,       32'h0,       32'h00002000, 0, 32'h0,       0, 0, 30'h0,   4'h0, 0, 0, 0, 0, 0,  1, 1, 16'h2000, 0);
        add(32'h0,       32'h0,       32'h0,       32'h00002000, 0, 32'h0,       0, 0, 30'h0,   4'h0, 0, 0, 0, 0, 1,  0, 0, 16'h0000, 0);
        add(32'h0,       32'h2000,    32'h0,       32'h0000200C, 1, 32'h2000,    0, 0, 30'h0,   4'h0, 0, 0, 0, 1, 0,  1, 1, 16'h2002, 1);
        add(32'h0,       32'h0,       32'h0,       32'h0,        0, 32'h0,       0, 0, 30'h0,   4'h0, 0, 0, 0, 0, 1,  0, 0, 16'h0000, 0);
        add(32'h1000,    32'h0,       32'h3000,    32'h0D0D0011, 0, 32'h0,       0, 1, 30'h400, 4'hF, 1, 0, 0, 0, 0,  0, 0, 16'h0000, 0);
        add(32'h1000,    32'h0,       32'h3000,    32'h0D0D0011, 0, 32'h0,       0, 1, 30'hC00, 4'h1, 1, 0, 0, 0, 0,  0, 0, 16'h0000, 0);
        add(32'h1000,    32'h0,       32'h3000,    32'h0D0D0011, 0, 32'h0,       0, 0, 30'h0,   4'h0, 0, 1, 0, 0, 0,  1, 0, 16'h0005, 0);
        add(32'h1000,    32'h0,       32'h3000,    32'h0D0D0011, 0, 32'h0,       0, 0, 30'h0,   4'h0, 0, 0, 0, 0, 1,  0, 0, 16'h0000, 0);
        add(32'h1000,    32'h0,       32'h3000,    32'h0D0D0011, 0, 32'h0,       0, 1, 30'h400, 4'hF, 1, 0, 0, 0, 0,  0, 0, 16'h0000, 0);
        add(32'h1000,    32'h0,       32'h3000,    32'h0D0D0011, 0, 32'h0,       0, 0, 30'h0,   4'h0, 0, 0, 1, 0, 0,  0, 0, 16'h0000, 0);
        add(32'h1000,    32'h0,       32'h3000,    32'h0D0D0011, 0, 32'h0,       0, 0, 30'h0,   4'h0, 0, 1, 0, 0, 0,  0, 0, 16'h0000, 0);
        add(32'h1000,    32'h0,       32'h3000,    32'h0D0D0011, 0, 32'h0,       0, 1, 30'h400, 4'hF, 1, 1, 1, 0, 0,  0, 0, 16'h0000, 0);

        foreach (vecs[k]) begin
            dr_addr[0] = vecs[k].dr0; dr_addr[1] = vecs[k].dr1; dr_addr[2] = vecs[k].dr2; dr_addr[3] = '0;
            dr7 = vecs[k].dr7v;
            insn_start_valid = vecs[k].isv; insn_start_addr = vecs[k].isa; eflags_rf = vecs[k].rf;
            access_valid = vecs[k].av; access_addr = vecs[k].aa; access_be = vecs[k].be; access_write = vecs[k].wr;
            insn_retire = vecs[k].ret; insn_flush = vecs[k].fl; dr_access_valid = vecs[k].dav; debug_ack = vecs[k].ack;
            @(posedge clock);
            #1;
            check_outs("vec", k, vecs[k].ereq, vecs[k].efault, vecs[k].est, vecs[k].egd);
        end

        // Asynchronous reset while a request is outstanding.
        idle_inputs();
        dr7 = 32'h00002000; dr_access_valid = 1;
        @(posedge clock);
        #1;
        check_outs("rst_pre", 0, 1, 1, 16'h2000, 1);
        idle_inputs();
        #2;
        reset_n = 0;
        #1;
        check_outs("rst_async", 0, 0, 0, 16'h0, 0);
        @(posedge clock);
        #1;
        reset_n = 1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clock);
            #1;
            check_outs("rst_after", c, 0, 0, 16'h0, 0);
        end

        m_req = 0; m_fault = 0; m_gd = 0; m_st = 0; m_pend = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) dr_addr[i] = 32'h1000 + $urandom_range(0, 15);
            dr7 = $urandom;
            if ($urandom_range(0, 7) != 0) dr7[13] = 1'b0;
            insn_start_valid = ($urandom_range(0, 2) == 0);
            insn_start_addr  = ($urandom_range(0, 1) == 0) ? dr_addr[$urandom_range(0, 3)] : 32'h1000 + $urandom_range(0, 15);
            eflags_rf        = ($urandom_range(0, 1) == 0);
            access_valid     = ($urandom_range(0, 1) == 0);
            access_addr      = 30'h400 + 30'($urandom_range(0, 3));
            access_be        = 4'($urandom_range(0, 15));
            access_write     = ($urandom_range(0, 1) == 0);
            insn_retire      = ($urandom_range(0, 2) == 0);
            insn_flush       = ($urandom_range(0, 5) == 0);
            dr_access_valid  = ($urandom_range(0, 3) == 0);
            debug_ack        = ($urandom_range(0, 2) == 0);
            model_step();
            @(posedge clock);
            #1;
            check_outs("rand", c, m_req, m_fault, m_st, m_gd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/debug_breakpoint_unit.md
Name: debug_breakpoint_unit

Overview:
- Consumer side of the debug register file: reads DR0–DR3 and DR7 and watches linear instruction-start and data-access traffic.
- Detects breakpoint hits, GD (general detect) violations and, optionally, single-step.
- Raises a debug exception request (#DB, vector 1) to the exception unit with a req/ack handshake, plus the DR6 status bits to be written back.
- Sits between the register file, the bus/paging front-end and the exception sequencer.

Parameters:
- NUM_BP, 4, number of address breakpoints compared (DR0..DR(NUM_BP-1)); fixed at 4 for 80386 compatibility.

Ports:
- clock  input  1  core clock
- reset_n  input  1  asynchronous active-low reset
- dr_addr  input  32x4  DR0–DR3 linear breakpoint addresses
- dr7  input  32  DR7 control: L/G at bits 2i/2i+1, GD bit 13, RW_i at 16+4i, LEN_i at 18+4i
- insn_start_valid  input  1  first-byte decode of a new instruction
- insn_start_addr  input  32  linear address of that instruction
- eflags_rf  input  1  resume flag; suppresses instruction-breakpoint faults
- access_valid  input  1  one dword-aligned data access this cycle
- access_addr  input  30  linear address [31:2]
- access_be  input  4  byte enables within the dword
- access_write  input  1  1 = write, 0 = read
- insn_retire  input  1  current instruction completes this cycle
- insn_flush  input  1  current instruction aborted; discard pending trap bits
- dr_access_valid  input  1  MOV to/from a DRn is being decoded
- debug_req  output  1  #DB request to exception unit
- debug_fault  output  1  1 = fault (instruction bp/GD), 0 = trap (data bp/single-step)
- dr6_status  output  16  DR6 bits: B0–B3 [3:0], BD [13], BS [14]; other bits 0
- debug_ack  input  1  exception unit accepted the request
- gd_clear  output  1  one-cycle pulse: clear DR7.GD (issued on BD entry)

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE; debug_req=0, debug_fault=0, dr6_status=0, gd_clear=0, pending bits=0.
- Enable: bp i is enabled when L_i | G_i.
- Byte mask by LEN:
  - 00 → 1 << dr[1:0]
  - 01 → 2'b11 << {dr[1],1'b0}
  - 11 → 4'hF
  - 10 (undefined) → treated as 00
- Data match: enabled, RW in {01 write-only, 11 read/write}, access_addr == dr[31:2], and (mask & access_be) != 0. RW=01 ignores reads; RW=10 never matches.
- Instruction match: enabled, RW=00, LEN=00, insn_start_valid, insn_start_addr == dr exactly, eflags_rf=0.
- Priority when simultaneous: fault events (GD, instruction bp) win over trap accumulation in the same cycle. GD wins over instruction bp, but the status reports BD plus any instruction-bp B bits.
- States:
  - IDLE
    - GD violation (dr7[13] & dr_access_valid): → REQ with fault=1, status BD=1, gd_clear pulse in the same cycle as the transition.
    - Instruction match: → REQ with fault=1, B bits of the matching bps.
    - Data match: OR B bits into pending; → ACCUM, or directly → REQ if insn_retire is in the same cycle.
  - ACCUM
    - Further data matches OR into pending.
    - insn_retire: → REQ with fault=0, status = pending | matches in the same cycle.
    - insn_flush: clear pending, → IDLE.
    - flush and retire in the same cycle: flush wins.
  - REQ
    - debug_req=1 and dr6_status held stable until debug_ack.
    - All new events ignored; the core stalls.
    - On debug_ack: → IDLE next cycle, pending and status cleared.
- Latency: debug_req asserts exactly one cycle after the triggering event (registered outputs).
- debug_ack outside REQ is ignored.
- DR0–DR7 changes take effect on the next compare; no shadowing.

Optional Feature:
- Macro: DEBUG_BREAKPOINT_SINGLE_STEP_EN.
- Enabled:
  - Adds input eflags_tf.
  - On insn_retire with eflags_tf=1, BS (bit 14) is set and a trap request raised, merged with any pending data B bits into one request.
  - insn_flush clears BS like pending bits.
- Disabled: no eflags_tf port; BS always 0.

Decomposition:
- Package debug_pkg:
  - RW enum (EXEC=00, WRITE=01, IO=10, RDWR=11)
  - LEN enum
  - DR7 field offset constants (L, G, GD, RW, LEN)
  - DR6 bit positions (B0..B3, BD, BS)
  - FSM state enum
- Sub-module debug_bp_compare: combinational per-breakpoint enable/mask/RW/address match; instantiated NUM_BP times.

Test Plan:
- Data write hit: DR0=0x00001000, dr7=0x000D0001. Write access_addr=0x400, be=0100, then retire → debug_req=1 next cycle, fault=0, dr6_status=0x0001. Ack → req=0.
- RW filter: same setup but a read access, then retire → no debug_req. LEN=00 with DR0=0x1001 and be=0001 → no req; be=0010 → req.
- Instruction bp: DR1=0x00002000, dr7=0x00000008. insn_start_addr=0x2000 with rf=0 → req, fault=1, status=0x0002. Same with rf=1 → no req.
- GD: dr7=0x00002000, dr_access_valid=1 → req, fault=1, status=0x2000, gd_clear pulsed one cycle.
- Flush and multi-hit: DR0 and DR2 both hit in one instruction, then retire → status=0x0005. Hit followed by insn_flush, then retire → no req.
- Reset mid-request: in REQ, pull reset_n low asynchronously → debug_req=0 and status=0 immediately. After release, stay IDLE with no spurious req.
